// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic inter-stage pipeline register with bubble/flush handling
// Optional stall/bubble counters are enabled by defining PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_reg #(
  parameter int unsigned           PAYLOAD_W = 192,
  parameter int unsigned           PC_W      = 32,
  parameter int unsigned           EXC_W     = 5,
  parameter logic [PC_W-1:0]       PC_RST    = 32'h0000_3000,
  parameter logic [PC_W-1:0]       PC_EXC    = 32'h0000_4180
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 exc_flush,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [EXC_W-1:0]     in_exccode,
  input  logic                 in_delayslot,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [PC_W-1:0]      out_pc,
  output logic [EXC_W-1:0]     out_exccode,
  output logic                 out_delayslot
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          bubble_cnt
`endif
);

  // Priority per edge: reset > exc_flush > stall > flush > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_payload   <= '0;
      out_pc        <= PC_RST;
      out_exccode   <= '0;
      out_delayslot <= 1'b0;
    end else if (exc_flush) begin
      out_valid     <= 1'b0;
      out_payload   <= '0;
      out_pc        <= PC_EXC;
      out_exccode   <= '0;
      out_delayslot <= 1'b0;
    end else if (!stall) begin
      // Bubbles still carry pc/delayslot so an interrupt on the bubble yields a correct EPC.
      out_pc        <= in_pc;
      out_delayslot <= in_delayslot;
      if (flush || !in_valid) begin
        out_valid   <= 1'b0;
        out_payload <= '0;
        out_exccode <= '0;
      end else begin
        out_valid   <= 1'b1;
        out_payload <= in_payload;
        out_exccode <= in_exccode;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic stall_hit;
  logic bubble_hit;

  assign stall_hit  = stall && !exc_flush;
  assign bubble_hit = !exc_flush && !stall && (flush || !in_valid);

  // Counters saturate rather than wrap; exc_flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_hit && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (bubble_hit && (bubble_cnt != 32'hFFFF_FFFF)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
// Counter checks are compiled in when PIPE_STAGE_PERF_CNT_EN is defined.
module tb_pipe_stage_reg;
  localparam int PW = 192;

  logic          clk = 1'b0;
  logic          reset, stall, flush, exc_flush, in_valid, in_delayslot;
  logic [PW-1:0] in_payload;
  logic [31:0]   in_pc;
  logic [4:0]    in_exccode;
  logic          out_valid, out_delayslot;
  logic [PW-1:0] out_payload;
  logic [31:0]   out_pc;
  logic [4:0]    out_exccode;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0]   stall_cnt, bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .exc_flush(exc_flush),
    .in_valid(in_valid), .in_payload(in_payload), .in_pc(in_pc),
    .in_exccode(in_exccode), .in_delayslot(in_delayslot),
    .out_valid(out_valid), .out_payload(out_payload), .out_pc(out_pc),
    .out_exccode(out_exccode), .out_delayslot(out_delayslot)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          rst, stl, fls, exf, vld, ds;
    logic [PW-1:0] pay;
    logic [31:0]   pc;
    logic [4:0]    exc;
    logic          e_vld, e_ds;
    logic [PW-1:0] e_pay;
    logic [31:0]   e_pc;
    logic [4:0]    e_exc;
  } vec_t;

  typedef struct {
    string         name;
    logic          vld, ds;
    logic [PW-1:0] pay;
    logic [31:0]   pc;
    logic [4:0]    exc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  localparam logic [PW-1:0] ONES = {PW{1'b1}};
  localparam logic [PW-1:0] PA   = {6{32'hA5A5_0001}};
  localparam logic [PW-1:0] PB   = {6{32'h1234_5678}};
  localparam logic [PW-1:0] PC_  = {6{32'hDEAD_BEEF}};
  localparam logic [PW-1:0] PE   = {6{32'h0BAD_F00D}};

  function automatic vec_t mk(string n, logic rst, logic stl, logic fls, logic exf,
                              logic vld, logic [PW-1:0] pay, logic [31:0] pc,
                              logic [4:0] exc, logic ds, logic e_vld,
                              logic [PW-1:0] e_pay, logic [31:0] e_pc,
                              logic [4:0] e_exc, logic e_ds);
    vec_t v;
    v.name = n; v.rst = rst; v.stl = stl; v.fls = fls; v.exf = exf; v.vld = vld;
    v.pay = pay; v.pc = pc; v.exc = exc; v.ds = ds;
    v.e_vld = e_vld; v.e_pay = e_pay; v.e_pc = e_pc; v.e_exc = e_exc; v.e_ds = e_ds;
    return v;
  endfunction

  task automatic check(string n, logic [PW-1:0] act, logic [PW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endtask

  // Drive one edge's inputs, push the expected result, then compare after the edge.
  task automatic step(vec_t v);
    exp_t e;
    reset = v.rst; stall = v.stl; flush = v.fls; exc_flush = v.exf;
    in_valid = v.vld; in_payload = v.pay; in_pc = v.pc; in_exccode = v.exc;
    in_delayslot = v.ds;
    e.name = v.name; e.vld = v.e_vld; e.pay = v.e_pay; e.pc = v.e_pc;
    e.exc = v.e_exc; e.ds = v.e_ds;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.name, ".valid"},     PW'(out_valid),     PW'(e.vld));
    check({e.name, ".payload"},   out_payload,        e.pay);
    check({e.name, ".pc"},        PW'(out_pc),        PW'(e.pc));
    check({e.name, ".exccode"},   PW'(out_exccode),   PW'(e.exc));
    check({e.name, ".delayslot"}, PW'(out_delayslot), PW'(e.ds));
  endtask

  initial begin
    //            name         rst stl fls exf vld payload pc          exc    ds   e_vld e_pay e_pc        e_exc  e_ds
    vecs.push_back(mk("reset",      1, 0, 0, 0, 1, PA,   32'h3008, 5'd3,  1, 0, '0,   32'h3000, 5'd0, 0));
    vecs.push_back(mk("load1",      0, 0, 0, 0, 1, ONES, 32'h3010, 5'd0,  0, 1, ONES, 32'h3010, 5'd0, 0));
    vecs.push_back(mk("load2",      0, 0, 0, 0, 1, PA,   32'h3020, 5'd3,  0, 1, PA,   32'h3020, 5'd3, 0));
    vecs.push_back(mk("stall1",     0, 1, 0, 0, 1, PB,   32'h3024, 5'd1,  1, 1, PA,   32'h3020, 5'd3, 0));
    vecs.push_back(mk("stall2",     0, 1, 1, 0, 0, PC_,  32'h3028, 5'd2,  1, 1, PA,   32'h3020, 5'd3, 0));
    vecs.push_back(mk("stall3",     0, 1, 0, 0, 1, PE,   32'h302c, 5'd4,  0, 1, PA,   32'h3020, 5'd3, 0));
    vecs.push_back(mk("post_stall", 0, 0, 0, 0, 1, PB,   32'h3030, 5'd0,  1, 1, PB,   32'h3030, 5'd0, 1));
    vecs.push_back(mk("bubble",     0, 0, 1, 0, 1, PC_,  32'h3034, 5'd10, 1, 0, '0,   32'h3034, 5'd0, 1));
    vecs.push_back(mk("inv_load",   0, 0, 0, 0, 0, PB,   32'h3038, 5'd7,  0, 0, '0,   32'h3038, 5'd0, 0));
    vecs.push_back(mk("load3",      0, 0, 0, 0, 1, PE,   32'h3040, 5'd0,  0, 1, PE,   32'h3040, 5'd0, 0));
    vecs.push_back(mk("exc_all",    0, 1, 1, 1, 1, PA,   32'h3044, 5'd9,  1, 0, '0,   32'h4180, 5'd0, 0));
    vecs.push_back(mk("exc_hold",   0, 1, 0, 0, 1, PB,   32'h3048, 5'd5,  1, 0, '0,   32'h4180, 5'd0, 0));
    vecs.push_back(mk("load4",      0, 0, 0, 0, 1, PE,   32'h3040, 5'd2,  1, 1, PE,   32'h3040, 5'd2, 1));
    vecs.push_back(mk("rst_stall",  1, 1, 0, 0, 1, PA,   32'h3050, 5'd6,  1, 0, '0,   32'h3000, 5'd0, 0));
    vecs.push_back(mk("exc_only",   0, 0, 0, 1, 1, PB,   32'h3054, 5'd1,  1, 0, '0,   32'h4180, 5'd0, 0));

    foreach (vecs[i]) step(vecs[i]);

    // Long stall with random inputs: the last loaded value must hold throughout.
    step(mk("pre_rs", 0, 0, 0, 0, 1, PB, 32'h3100, 5'd4, 1, 1, PB, 32'h3100, 5'd4, 1));
    for (int k = 0; k < 6; k++) begin
      step(mk("rand_stall", 0, 1, 1'($urandom), 0, 1'($urandom),
              {6{32'($urandom)}}, 32'($urandom), 5'($urandom), 1'($urandom),
              1, PB, 32'h3100, 5'd4, 1));
    end
    step(mk("rs_release", 0, 0, 0, 0, 1, PA, 32'h3104, 5'd0, 0, 1, PA, 32'h3104, 5'd0, 0));

`ifdef PIPE_STAGE_PERF_CNT_EN
    step(mk("cnt_rst", 1, 0, 0, 0, 0, '0, 32'h0, 5'd0, 0, 0, '0, 32'h3000, 5'd0, 0));
    check("cnt_rst.stall_cnt",  PW'(stall_cnt),  PW'(0));
    check("cnt_rst.bubble_cnt", PW'(bubble_cnt), PW'(0));
    step(mk("c_load", 0, 0, 0, 0, 1, PA, 32'h3200, 5'd0, 0, 1, PA, 32'h3200, 5'd0, 0));
    for (int k = 0; k < 4; k++)
      step(mk("c_stall", 0, 1, 1, 0, 0, PB, 32'h3204, 5'd0, 0, 1, PA, 32'h3200, 5'd0, 0));
    step(mk("c_fl1", 0, 0, 1, 0, 1, PB, 32'h3208, 5'd0, 0, 0, '0, 32'h3208, 5'd0, 0));
    step(mk("c_fl2", 0, 0, 1, 0, 1, PB, 32'h320c, 5'd0, 0, 0, '0, 32'h320c, 5'd0, 0));
    step(mk("c_inv", 0, 0, 0, 0, 0, PB, 32'h3210, 5'd0, 0, 0, '0, 32'h3210, 5'd0, 0));
    step(mk("c_exf", 0, 1, 1, 1, 0, PB, 32'h3214, 5'd0, 0, 0, '0, 32'h4180, 5'd0, 0));
    check("perf.stall_cnt",  PW'(stall_cnt),  PW'(4));
    check("perf.bubble_cnt", PW'(bubble_cnt), PW'(3));
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    step(mk("c_sat", 0, 1, 0, 0, 1, PB, 32'h3218, 5'd0, 0, 0, '0, 32'h4180, 5'd0, 0));
    check("sat.stall_cnt", PW'(stall_cnt), PW'(32'hFFFF_FFFF));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
